// File: rtl/alu_byte_master.sv
// alu_byte_master: host-side sequencer for the 16-bit byte-serial ALU.
// Takes one (A, B, opcode) command on a valid/ready handshake and sends it
// as the ALU's 4-byte frame, lined up with the ALU's free-running loader
// phase. It then captures the 12-bit result and four flags, and returns
// them on a valid/ready response port.
// Optional feature macro: ALU_MASTER_RANGE_CHECK_EN. When it is defined,
// a command whose A[15:12] is non-zero is answered at once with rsp_err=1
// and no frame is sent.
module alu_byte_master #(
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [3:0]  cmd_op,
    output logic [7:0]  byte_out,
    input  logic [7:0]  res_lo,
    input  logic [7:0]  res_hi,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [11:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [15:0] xfer_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ALIGN   = 3'd1,
        ST_SEND    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  ph_r;
    logic [11:0] a_r;
    logic [15:0] b_r;
    logic [3:0]  op_r;
    logic        cmd_ready_r;
    logic        rsp_valid_r;
    logic [11:0] rsp_result_r;
    logic [3:0]  rsp_flags_r;
    logic [15:0] xfer_count_r;
    logic [7:0]  byte_s;
    logic        accept_s;
    logic        rsp_hs_s;
    logic        range_bad_s;

    assign accept_s = cmd_valid && cmd_ready_r;
    assign rsp_hs_s = rsp_valid_r && rsp_ready;

`ifdef ALU_MASTER_RANGE_CHECK_EN
    logic rsp_err_r;

    // A[15:12] cannot be carried by the frame, so a non-zero value is rejected.
    assign range_bad_s = (cmd_a[15:12] != 4'h0);
    assign rsp_err     = rsp_err_r;

    // Error flag: set for a rejected command, cleared for a normal capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_err_r <= 1'b0;
        end else if (state_r == ST_IDLE && accept_s) begin
            rsp_err_r <= range_bad_s;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end
`else
    logic unused_upper_s;

    // A[15:12] is dropped without notice, and no error is ever reported.
    assign unused_upper_s = ^cmd_a[15:12];
    assign range_bad_s    = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    // Loader phase: counts mod 4 on every cycle, the same way the ALU does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_r <= 2'd0;
        end else begin
            ph_r <= ph_r + 2'd1;
        end
    end

    // Next-state logic for the command / frame / response sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_s = ST_IDLE;
                end else if (range_bad_s) begin
                    state_s = ST_RESP;
                end else if (ph_r == 2'd3) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (ph_r == 2'd3) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_ALIGN;
                end
            end
            ST_SEND: begin
                if (ph_r == 2'd3) begin
                    state_s = ST_CAPTURE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_CAPTURE: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register. The handshake flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP);
        end
    end

    // Operand latch: loaded only when a command is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r  <= 12'h000;
            b_r  <= 16'h0000;
            op_r <= 4'h0;
        end else if (state_r == ST_IDLE && accept_s) begin
            a_r  <= cmd_a[11:0];
            b_r  <= cmd_b;
            op_r <= cmd_op;
        end else begin
            a_r  <= a_r;
            b_r  <= b_r;
            op_r <= op_r;
        end
    end

    // Response capture: the ALU result is valid during ph0 right after the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_result_r <= 12'h000;
            rsp_flags_r  <= 4'h0;
        end else if (state_r == ST_CAPTURE) begin
            rsp_result_r <= {res_hi[3:0], res_lo};
            rsp_flags_r  <= res_hi[7:4];
        end else if (state_r == ST_IDLE && accept_s && range_bad_s) begin
            rsp_result_r <= 12'h000;
            rsp_flags_r  <= 4'h0;
        end else begin
            rsp_result_r <= rsp_result_r;
            rsp_flags_r  <= rsp_flags_r;
        end
    end

    // Completed-response counter: wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count_r <= 16'h0000;
        end else if (rsp_hs_s) begin
            xfer_count_r <= xfer_count_r + 16'd1;
        end else begin
            xfer_count_r <= xfer_count_r;
        end
    end

    // Frame byte mux: depends only on registered state, phase and latched operands.
    always_comb begin
        byte_s = IDLE_BYTE;
        if (state_r == ST_SEND) begin
            case (ph_r)
                2'd0:    byte_s = a_r[7:0];
                2'd1:    byte_s = {a_r[11:8], op_r};
                2'd2:    byte_s = b_r[7:0];
                2'd3:    byte_s = b_r[15:8];
                default: byte_s = IDLE_BYTE;
            endcase
        end else begin
            byte_s = IDLE_BYTE;
        end
    end

    assign byte_out   = byte_s;
    assign cmd_ready  = cmd_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_flags  = rsp_flags_r;
    assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_alu_byte_master.sv
// Testbench for alu_byte_master. It runs a byte-serial ALU stand-in that
// reads the frame from byte_out. Each response is checked against a
// reference model built from the command fields and the expected frame
// timing.
module tb_alu_byte_master;

    localparam logic [7:0] IDLE_B = 8'h00;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_op;
    logic [7:0]  byte_out;
    logic [7:0]  res_lo;
    logic [7:0]  res_hi;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [15:0] xfer_count;

    int n_assert;
    int n_fail;
    int exp_count;

    alu_byte_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .byte_out   (byte_out),
        .res_lo     (res_lo),
        .res_hi     (res_hi),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU behaviour: returns {zero, carry, overflow, negative, result[11:0]}.
    function automatic logic [15:0] ref_alu(input logic [11:0] a, input logic [15:0] b16, input logic [3:0] op);
        logic [12:0] wide;
        logic [11:0] b;
        logic [11:0] r;
        logic        c;
        logic        v;
        b = b16[11:0];
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[11:0];
                c = wide[12];
                v = (a[11] == b[11]) && (r[11] != a[11]);
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
                v = (a[11] != b[11]) && (r[11] != a[11]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {(r == 12'd0), c, v, r[11], r};
    endfunction

    // ALU stand-in: takes byte p at the end of phase p and shows the result during the next ph0.
    logic [1:0]  aph;
    logic [7:0]  fa_lo;
    logic [7:0]  fa_hi;
    logic [7:0]  fb_lo;
    logic [15:0] res_r;
    always @(posedge clk) begin
        if (!rst_n) begin
            aph   <= 2'd0;
            res_r <= 16'h0000;
        end else begin
            aph <= aph + 2'd1;
            case (aph)
                2'd0: fa_lo <= byte_out;
                2'd1: fa_hi <= byte_out;
                2'd2: fb_lo <= byte_out;
                default: res_r <= ref_alu({fa_hi[7:4], fa_lo}, {byte_out, fb_lo}, fa_hi[3:0]);
            endcase
        end
    end
    assign res_lo = res_r[7:0];
    assign res_hi = res_r[15:8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for cmd_ready (and the wanted phase), then hands over one command. Returns at the first negedge after acceptance.
    task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                            input int want_ph, input bit keep, output int p);
        int guard;
        cmd_a  = a;
        cmd_b  = b;
        cmd_op = op;
        if (want_ph >= 0) cmd_valid = 1'b0;
        guard = 0;
        while (!(cmd_ready === 1'b1 && (want_ph < 0 || int'(aph) == want_ph)) && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_timeout", (guard < 64), 1'b1);
        cmd_valid = 1'b1;
        p = int'(aph);
        @(posedge clk);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    // Checks frame timing, latency, the held response and completion. exp = {flags, result}.
    task automatic check_rest(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                              input int p, input int hold, input logic [15:0] exp_in);
        logic [7:0]  fr [4];
        logic [15:0] exp;
        int          n_al;
        bit          err_path;
        exp   = exp_in;
        fr[0] = a[7:0];
        fr[1] = {a[11:8], op};
        fr[2] = b[7:0];
        fr[3] = b[15:8];
        n_al  = 3 - p;
        err_path = 1'b0;
`ifdef ALU_MASTER_RANGE_CHECK_EN
        err_path = (a[15:12] != 4'h0);
`endif
        rsp_ready = (hold == 0);
        if (err_path) begin
            exp = 16'h0000;
            chk("err_latency_valid", rsp_valid, 1'b1);
            chk("err_flag", rsp_err, 1'b1);
            chk("err_no_frame", byte_out, IDLE_B);
        end else begin
            for (int k = 1; k <= n_al + 5; k++) begin
                if (k > 1) @(negedge clk);
                chk("busy_cmd_ready", cmd_ready, 1'b0);
                chk("early_rsp_valid", rsp_valid, 1'b0);
                if (k > n_al && k <= n_al + 4) chk("frame_byte", byte_out, fr[k - n_al - 1]);
                else                           chk("idle_byte", byte_out, IDLE_B);
            end
            @(negedge clk);
            chk("latency_rsp_valid", rsp_valid, 1'b1);
            chk("rsp_err_clear", rsp_err, 1'b0);
        end
        chk("rsp_result", rsp_result, exp[11:0]);
        chk("rsp_flags", rsp_flags, exp[15:12]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_result", rsp_result, exp[11:0]);
            chk("hold_flags", rsp_flags, exp[15:12]);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_count = (exp_count + 1) & 16'hFFFF;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("xfer_count", xfer_count, exp_count[15:0]);
        chk("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [3:0]  rop;
        logic [15:0] bb_a [3];
        logic [15:0] bb_b [3];
        logic [3:0]  bb_op [3];
        int          bb_p [3];
        n_assert = 0;
        n_fail = 0;
        exp_count = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = 16'h0000;
        cmd_b = 16'h0000;
        cmd_op = 4'h0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_byte_out", byte_out, IDLE_B);
        chk("reset_result", rsp_result, 12'h000);
        chk("reset_flags", rsp_flags, 4'h0);
        chk("reset_err", rsp_err, 1'b0);
        chk("reset_xfer", xfer_count, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", cmd_ready, 1'b1);

        // ADD accepted at ph3: shortest latency.
        send_cmd(16'h0123, 16'h0456, 4'd0, 3, 1'b0, p);
        check_rest(16'h0123, 16'h0456, 4'd0, p, 0, {4'b0000, 12'h579});

        // SUB accepted at ph0: three align cycles, negative result with borrow.
        send_cmd(16'h0001, 16'h0002, 4'd1, 0, 1'b0, p);
        check_rest(16'h0001, 16'h0002, 4'd1, p, 0, {4'b0101, 12'hFFF});

        // Back-to-back, with cmd_valid held; the second response is held for 5 cycles.
        for (int i = 0; i < 3; i++) begin
            bb_a[i]  = {4'h0, 12'($urandom)};
            bb_b[i]  = 16'($urandom);
            bb_op[i] = 4'($urandom_range(0, 5));
        end
        for (int i = 0; i < 3; i++) begin
            send_cmd(bb_a[i], bb_b[i], bb_op[i], -1, (i < 2), bb_p[i]);
            check_rest(bb_a[i], bb_b[i], bb_op[i], bb_p[i], (i == 1) ? 5 : 0,
                       ref_alu(bb_a[i][11:0], bb_b[i], bb_op[i]));
        end
        chk("b2b_xfer_count", xfer_count, 16'd5);

        // Long backpressure.
        send_cmd(16'h0FFF, 16'h0001, 4'd0, -1, 1'b0, p);
        check_rest(16'h0FFF, 16'h0001, 4'd0, p, 10, {4'b1100, 12'h000});

        // Reset during SEND ph2: the command is aborted and no response appears.
        send_cmd(16'h0ABC, 16'h1234, 4'd2, 3, 1'b0, p);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_frame_b0", byte_out, 8'h34);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_byte_out", byte_out, IDLE_B);
        chk("midreset_rsp_valid", rsp_valid, 1'b0);
        chk("midreset_cmd_ready", cmd_ready, 1'b0);
        chk("midreset_xfer", xfer_count, 16'h0000);
        exp_count = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_orphan_rsp", rsp_valid, 1'b0);
        end
        send_cmd(16'h0321, 16'h0123, 4'd4, 1, 1'b0, p);
        check_rest(16'h0321, 16'h0123, 4'd4, p, 0, {4'b0000, 12'h202});

        // Upper A bits set: rejected with the feature enabled, dropped otherwise.
        send_cmd(16'h1000, 16'h0002, 4'd0, 2, 1'b0, p);
        check_rest(16'h1000, 16'h0002, 4'd0, p, 0, {4'b0000, 12'h002});

        // Random commands checked against the reference.
        for (int i = 0; i < 24; i++) begin
            ra  = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ra[15:12] = 4'h0;
            rb  = 16'($urandom);
            rop = 4'($urandom_range(0, 7));
            send_cmd(ra, rb, rop, int'($urandom_range(0, 4)) - 1, 1'b0, p);
            check_rest(ra, rb, rop, p, int'($urandom_range(0, 3)), ref_alu(ra[11:0], rb, rop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
